// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core: opcodes, fetch FSM states, PC increment.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int unsigned PC_INC       = 4;
    localparam int unsigned JUMP_INDEX_W = 26;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetchState_t;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC select: jump > taken branch > sequential, all arithmetic modulo 2^WIDTH.
module mips_next_pc
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]        pcPlus4,
    input  logic                    jump,
    input  logic [JUMP_INDEX_W-1:0] jumpIndex,
    input  logic                    branchTaken,
    input  logic [WIDTH-1:0]        branchOffset,
    output logic [WIDTH-1:0]        nextPc_c
);

    always_comb begin
        nextPc_c = pcPlus4;
        if (jump) begin
            nextPc_c = WIDTH'({pcPlus4[WIDTH-1 -: 4], jumpIndex, 2'b00});
        end else if (branchTaken) begin
            nextPc_c = pcPlus4 + (branchOffset << 2);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ready handshake, instruction hold until retire.
// Optional FETCH_COUNT_EN adds a retired-instruction counter output instr_count.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned    WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [WIDTH-1:0]        branch_offset,
    input  logic                    jump,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    output logic                    imem_req,
    output logic [WIDTH-1:0]        imem_addr,
    input  logic                    imem_ready,
    input  logic [WIDTH-1:0]        imem_rdata,
    output logic [WIDTH-1:0]        instr,
    output logic                    instr_valid,
    output logic [5:0]              opcode,
    output logic [5:0]              funct,
    output logic [WIDTH-1:0]        pc,
    output logic [WIDTH-1:0]        pc_plus4
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]             instr_count
`endif
);

    fetchState_t      state;
    fetchState_t      stateNext;
    logic             loadInstr;
    logic             retire;
    logic [WIDTH-1:0] nextPc;

    mips_next_pc #(
        .WIDTH(WIDTH)
    ) uNextPc (
        .pcPlus4     (pc_plus4),
        .jump        (jump),
        .jumpIndex   (jump_index),
        .branchTaken (branch_taken),
        .branchOffset(branch_offset),
        .nextPc_c    (nextPc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // stall only matters in HOLD; imem_ready only matters in REQ
    always_comb begin
        stateNext = state;
        loadInstr = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: stateNext = REQ;
            REQ: begin
                if (imem_ready) begin
                    stateNext = HOLD;
                    loadInstr = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    stateNext = REQ;
                    retire    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc          <= RESET_PC;
            pc_plus4    <= RESET_PC + WIDTH'(PC_INC);
        end else begin
            imem_req    <= (stateNext == REQ);
            instr_valid <= (stateNext == HOLD);
            if (loadInstr) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc       <= nextPc;
                pc_plus4 <= nextPc + WIDTH'(PC_INC);
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= 32'd0;
        end else if (retire) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

    assign imem_addr = pc;
    assign opcode    = instr[WIDTH-1 -: 6];
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: expected fetch PCs are queued at each retire and
// compared when the held instruction appears.
module tb_mips_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef FETCH_COUNT_EN
    logic [31:0] instrCount;
`endif

    logic [31:0] memSalt;
    logic [31:0] expPc;
    logic [31:0] expQ[$];
    int          numCompared;
    int          numMismatched;
    int          retires;
    int          lat;

    mips_fetch_unit #(
        .WIDTH   (32),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .funct        (funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
`ifdef FETCH_COUNT_EN
        ,
        .instr_count  (instrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0C3F};
    endfunction

    always_comb imem_rdata = memWord(imem_addr) ^ memSalt;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // wait (bounded) for a held instruction, then pop and compare against the scoreboard
    task automatic waitHold(input int bound, output int cycles);
        logic [31:0] e;
        logic [31:0] ei;
        cycles = 0;
        while (instr_valid !== 1'b1 && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
        if (instr_valid !== 1'b1) begin
            checkVal("holdTimeout", 32'(instr_valid), 32'd1);
        end else if (expQ.size() == 0) begin
            checkVal("sbEmpty", 32'd0, 32'd1);
        end else begin
            e  = expQ.pop_front();
            ei = memWord(e);
            checkVal("holdPc", pc, e);
            checkVal("holdInstr", instr, ei);
            checkVal("holdPc4", pc_plus4, e + 32'd4);
            checkVal("holdOpcode", 32'(opcode), 32'(ei[31:26]));
            checkVal("holdFunct", 32'(funct), 32'(ei[5:0]));
        end
    endtask

    // one retire cycle from HOLD; returns at the following REQ negedge
    task automatic doRetire(input logic j, input logic bt, input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] p4;
        logic [31:0] nxt;
        p4 = expPc + 32'd4;
        if (j)       nxt = {p4[31:28], idx, 2'b00};
        else if (bt) nxt = p4 + {off[29:0], 2'b00};
        else         nxt = p4;
        jump = j; branch_taken = bt; branch_offset = off; jump_index = idx; stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        jump = 1'($urandom); branch_taken = 1'($urandom);
        branch_offset = $urandom; jump_index = 26'($urandom);
        expPc = nxt;
        retires++;
        checkVal("retireReq", 32'(imem_req), 32'd1);
        checkVal("retireAddr", imem_addr, expPc);
        checkVal("retireValid", 32'(instr_valid), 32'd0);
        expQ.push_back(expPc);
    endtask

    task automatic retireAndHold(input logic j, input logic bt, input logic [31:0] off, input logic [25:0] idx);
        int c;
        doRetire(j, bt, off, idx);
        waitHold(6, c);
        checkVal("fetchLat", 32'(c), 32'd1);
    endtask

    initial begin
        numCompared = 0; numMismatched = 0; retires = 0;
        rst = 1'b1; stall = 1'b1; jump = 1'b0; branch_taken = 1'b0;
        branch_offset = '0; jump_index = '0; imem_ready = 1'b1; memSalt = '0;
        expPc = RESET_PC;
        repeat (2) @(negedge clk);
        checkVal("rstReq", 32'(imem_req), 32'd0);
        checkVal("rstValid", 32'(instr_valid), 32'd0);
        checkVal("rstInstr", instr, 32'd0);
        checkVal("rstPc", pc, RESET_PC);
        checkVal("rstPc4", pc_plus4, RESET_PC + 32'd4);

        // reset release: one quiet IDLE cycle, then fetch at RESET_PC
        rst = 1'b0;
        #1 checkVal("idleReq", 32'(imem_req), 32'd0);
        expQ.push_back(expPc);
        @(negedge clk);
        checkVal("firstReq", 32'(imem_req), 32'd1);
        checkVal("firstAddr", imem_addr, 32'd0);
        waitHold(6, lat);
        checkVal("firstLat", 32'(lat), 32'd1);
        retireAndHold(1'b0, 1'b0, 32'h0, 26'h0);
        retireAndHold(1'b0, 1'b0, 32'h0, 26'h0);
        checkVal("seqPc8", pc, 32'h8);

        // wait states: req/addr stable while imem_ready is low
        doRetire(1'b0, 1'b0, 32'h0, 26'h0);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("waitReq", 32'(imem_req), 32'd1);
            checkVal("waitAddr", imem_addr, 32'hC);
            checkVal("waitValid", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        waitHold(6, lat);
        checkVal("waitLat", 32'(lat), 32'd1);

        // branches from pc 0x40, backwards and forwards
        retireAndHold(1'b1, 1'b0, $urandom, 26'h10);
        checkVal("jmpTo40", pc, 32'h40);
        retireAndHold(1'b0, 1'b1, 32'hFFFF_FFFE, 26'($urandom));
        checkVal("brBack", pc, 32'h3C);
        retireAndHold(1'b1, 1'b0, $urandom, 26'h10);
        retireAndHold(1'b0, 1'b1, 32'h0000_0003, 26'($urandom));
        checkVal("brFwd", pc, 32'h50);

        // jump wins over a taken branch
        retireAndHold(1'b0, 1'b1, (32'h1000_000C - expPc) >> 2, 26'h0);
        checkVal("brFar", pc, 32'h1000_0010);
        retireAndHold(1'b1, 1'b1, 32'h0000_0007, 26'h0000100);
        checkVal("jmpWins", pc, 32'h1000_0400);

        // stall in HOLD: everything held, no request, late ready and new rdata ignored
        memSalt = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'($urandom);
            branch_taken = 1'b1; jump = 1'($urandom);
            @(negedge clk);
            checkVal("stallInstr", instr, memWord(32'h1000_0400));
            checkVal("stallPc", pc, 32'h1000_0400);
            checkVal("stallValid", 32'(instr_valid), 32'd1);
            checkVal("stallReq", 32'(imem_req), 32'd0);
`ifdef FETCH_COUNT_EN
            checkVal("stallCount", instrCount, 32'(retires));
`endif
        end
        memSalt = '0;
        imem_ready = 1'b1;
        retireAndHold(1'b0, 1'b0, 32'h0, 26'h0);
        checkVal("stallRel", pc, 32'h1000_0404);

        // top-of-memory wrap on the sequential path
        retireAndHold(1'b0, 1'b1, (32'hFFFF_FFFC - (expPc + 32'd4)) >> 2, 26'h0);
        checkVal("brTop", pc, 32'hFFFF_FFFC);
        retireAndHold(1'b0, 1'b0, 32'h0, 26'h0);
        checkVal("seqWrap", pc, 32'h0);

        // async reset in the middle of a request
        doRetire(1'b0, 1'b0, 32'h0, 26'h0);
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkVal("midRstReq", 32'(imem_req), 32'd0);
        checkVal("midRstValid", 32'(instr_valid), 32'd0);
        checkVal("midRstAddr", imem_addr, RESET_PC);
        expQ.delete();
        imem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkVal("inRstValid", 32'(instr_valid), 32'd0);
            checkVal("inRstReq", 32'(imem_req), 32'd0);
        end
        rst = 1'b0;
        retires = 0;
        expPc = RESET_PC;
        expQ.push_back(expPc);
        @(negedge clk);
        checkVal("postRstReq", 32'(imem_req), 32'd1);
        checkVal("postRstAddr", imem_addr, RESET_PC);
        waitHold(6, lat);
`ifdef FETCH_COUNT_EN
        checkVal("countRst", instrCount, 32'd0);
`endif

        // ten retires with stalls interleaved
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) repeat (2) @(negedge clk);
            retireAndHold(1'b0, 1'b0, 32'h0, 26'h0);
        end
        checkVal("tenPc", pc, 32'h28);
`ifdef FETCH_COUNT_EN
        checkVal("tenCount", instrCount, 32'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
